// File: rtl/ddr3_port_arbiter_pkg.sv
// rtl/ddr3_port_arbiter_pkg.sv - shared encodings and helpers for the DDR3 port arbiter
package ddr3_port_arbiter_pkg;

  localparam logic [2:0] CMD_WR = 3'd0;
  localparam logic [2:0] CMD_RD = 3'd1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARB   = 3'd1;
  localparam logic [2:0] ST_CMD   = 3'd2;
  localparam logic [2:0] ST_WDATA = 3'd3;
  localparam logic [2:0] ST_RWAIT = 3'd4;

  typedef struct packed {
    logic we;
    logic idx;
  } owner_t;

  // Beat counter width that can hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ddr3_port_arbiter_if.sv
// rtl/ddr3_port_arbiter_if.sv - DDR3 IP native command/data port bundle
interface ddr3_port_arbiter_if #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 128
) ();
  logic                  init_done;
  logic                  cmd_rdy;
  logic [2:0]            cmd;
  logic                  cmd_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [5:0]            burst_number;
  logic                  wr_data_rdy;
  logic                  wr_data_en;
  logic                  wr_data_end;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_data_valid;

  modport master (
    input  init_done, cmd_rdy, wr_data_rdy, rd_data, rd_data_valid,
    output cmd, cmd_en, addr, burst_number, wr_data_en, wr_data_end, wr_data
  );

  modport slave (
    output init_done, cmd_rdy, wr_data_rdy, rd_data, rd_data_valid,
    input  cmd, cmd_en, addr, burst_number, wr_data_en, wr_data_end, wr_data
  );
endinterface

// File: rtl/ddr3_port_arbiter_rr_arb2.sv
// rtl/ddr3_port_arbiter_rr_arb2.sv - two-way round-robin grant with last-served pointer
module ddr3_port_arbiter_rr_arb2
  import ddr3_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] elig,
  input  logic       upd,
  input  logic       upd_idx,
  output logic       gnt_vld,
  output logic       gnt_idx
);
  logic last_q, last_d;

  always_comb begin
    last_d  = upd ? upd_idx : last_q;
    gnt_vld = |elig;
    gnt_idx = (elig == 2'b11) ? ~last_q : elig[1];
  end

  // Reset value 1 marks client 1 as last served, so client 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
endmodule

// File: rtl/ddr3_port_arbiter.sv
// rtl/ddr3_port_arbiter.sv - two-client round-robin arbiter for the DDR3 IP native port
// Burst/stall performance counters are added when DDR3_ARB_PERF_EN is defined.
module ddr3_port_arbiter
  import ddr3_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 128,
  parameter int WR_BEATS   = 16,
  parameter int RD_BEATS   = 8,
  parameter int RD_TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              c_req,
  input  logic [1:0]              c_we,
  input  logic [2*ADDR_WIDTH-1:0] c_addr,
  output logic [1:0]              c_gnt,
  input  logic [2*DATA_WIDTH-1:0] c_wdata,
  output logic [1:0]              c_wdata_rd,
  output logic [DATA_WIDTH-1:0]   c_rdata,
  output logic [1:0]              c_rdata_vld,
  output logic                    rd_timeout_err,
`ifdef DDR3_ARB_PERF_EN
  output logic [31:0]             wr_burst_cnt,
  output logic [31:0]             rd_burst_cnt,
  output logic [31:0]             stall_cnt,
`endif
  ddr3_port_arbiter_if.master     ip
);
  localparam int BEAT_W = cnt_width((WR_BEATS > RD_BEATS) ? WR_BEATS : RD_BEATS);
  localparam int TMO_W  = $clog2(RD_TIMEOUT + 2);

  logic [2:0]            state_q, state_d;
  owner_t                owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            cmd_q, cmd_d;
  logic [5:0]            burst_q, burst_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  err_q, err_d;

  logic [1:0]            elig;
  logic [1:0]            owner_oh;
  logic                  gnt_vld, gnt_idx;
  logic                  arb_take, arb_upd;
  logic                  wr_fire, rd_fire;
  logic [DATA_WIDTH-1:0] wsel;

  // A write is only worth granting when the IP can take its first beat.
  assign elig     = c_req & (~c_we | {2{ip.wr_data_rdy}}) & {2{ip.cmd_rdy}};
  assign arb_take = (state_q == ST_ARB) && ip.init_done && gnt_vld;
  assign arb_upd  = (state_q == ST_CMD);
  assign wr_fire  = (state_q == ST_WDATA) && ip.wr_data_rdy;
  assign rd_fire  = (state_q == ST_RWAIT) && ip.rd_data_valid;
  assign owner_oh = owner_q.idx ? 2'b10 : 2'b01;
  assign wsel     = owner_q.idx ? c_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : c_wdata[DATA_WIDTH-1:0];

  ddr3_port_arbiter_rr_arb2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .elig    (elig),
    .upd     (arb_upd),
    .upd_idx (owner_q.idx),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (ip.init_done) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (!ip.init_done) begin
          state_d = ST_IDLE;
        end else if (gnt_vld) begin
          owner_d.we  = c_we[gnt_idx];
          owner_d.idx = gnt_idx;
          addr_d      = gnt_idx ? c_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : c_addr[ADDR_WIDTH-1:0];
          cmd_d       = c_we[gnt_idx] ? CMD_WR : CMD_RD;
          burst_d     = c_we[gnt_idx] ? 6'(WR_BEATS - 1) : 6'(RD_BEATS - 1);
          state_d     = ST_CMD;
        end
      end
      ST_CMD: begin
        beat_d  = '0;
        tmo_d   = '0;
        state_d = owner_q.we ? ST_WDATA : ST_RWAIT;
      end
      ST_WDATA: begin
        if (wr_fire) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == BEAT_W'(WR_BEATS - 1)) state_d = ST_ARB;
        end
      end
      ST_RWAIT: begin
        tmo_d = tmo_q + 1'b1;
        // A last beat arriving on the timeout cycle still completes normally.
        if (rd_fire) beat_d = beat_q + 1'b1;
        if (rd_fire && (beat_q == BEAT_W'(RD_BEATS - 1))) begin
          state_d = ST_ARB;
        end else if (tmo_q > TMO_W'(RD_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = ST_ARB;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      addr_q  <= '0;
      cmd_q   <= CMD_RD;
      burst_q <= 6'(RD_BEATS - 1);
      beat_q  <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign ip.cmd_en       = (state_q == ST_CMD);
  assign ip.cmd          = cmd_q;
  assign ip.addr         = addr_q;
  assign ip.burst_number = burst_q;
  assign ip.wr_data_en   = wr_fire;
  assign ip.wr_data_end  = wr_fire;
  assign ip.wr_data      = wr_fire ? wsel : '0;

  assign c_gnt          = (state_q == ST_CMD) ? owner_oh : 2'b00;
  assign c_wdata_rd     = wr_fire ? owner_oh : 2'b00;
  assign c_rdata        = rd_fire ? ip.rd_data : '0;
  assign c_rdata_vld    = rd_fire ? owner_oh : 2'b00;
  assign rd_timeout_err = err_q;

`ifdef DDR3_ARB_PERF_EN
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    wr_cnt_d = wr_cnt_q + (((state_q == ST_CMD) && owner_q.we) ? 32'd1 : 32'd0);
    rd_cnt_d = rd_cnt_q + (((state_q == ST_CMD) && !owner_q.we) ? 32'd1 : 32'd0);
    stall_d  = stall_q + (((state_q == ST_ARB) && (|c_req) && !arb_take) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      stall_q  <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      stall_q  <= stall_d;
    end
  end

  assign wr_burst_cnt = wr_cnt_q;
  assign rd_burst_cnt = rd_cnt_q;
  assign stall_cnt    = stall_q;
`else
  logic unused_take;
  assign unused_take = arb_take;
`endif
endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// tb/tb_ddr3_port_arbiter.sv - scoreboard bench for the DDR3 port arbiter
module tb_ddr3_port_arbiter;
  localparam int AW  = 27;
  localparam int DW  = 128;
  localparam int WRB = 16;
  localparam int RDB = 8;
  localparam int TMO = 1023;

  typedef struct { logic we; logic [AW-1:0] addr; } req_t;
  typedef struct { int c; logic we; logic [AW-1:0] addr; } cmd_t;
  typedef struct { int c; logic [DW-1:0] d; } rbeat_t;

  logic            clk;
  logic            rst_n;
  logic [1:0]      c_req;
  logic [1:0]      c_we;
  logic [2*AW-1:0] c_addr;
  logic [1:0]      c_gnt;
  logic [2*DW-1:0] c_wdata;
  logic [1:0]      c_wdata_rd;
  logic [DW-1:0]   c_rdata;
  logic [1:0]      c_rdata_vld;
  logic            rd_timeout_err;
`ifdef DDR3_ARB_PERF_EN
  logic [31:0]     wr_burst_cnt, rd_burst_cnt, stall_cnt;
`endif

  ddr3_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ipb ();

  ddr3_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WR_BEATS(WRB), .RD_BEATS(RDB), .RD_TIMEOUT(TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .c_req          (c_req),
    .c_we           (c_we),
    .c_addr         (c_addr),
    .c_gnt          (c_gnt),
    .c_wdata        (c_wdata),
    .c_wdata_rd     (c_wdata_rd),
    .c_rdata        (c_rdata),
    .c_rdata_vld    (c_rdata_vld),
    .rd_timeout_err (rd_timeout_err),
`ifdef DDR3_ARB_PERF_EN
    .wr_burst_cnt   (wr_burst_cnt),
    .rd_burst_cnt   (rd_burst_cnt),
    .stall_cnt      (stall_cnt),
`endif
    .ip             (ipb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] wword(input int c, input int s);
    return {16'hC0DE, 16'(c), 32'(s), ~32'(s), 32'(s * 7 + c)};
  endfunction

  function automatic logic [DW-1:0] rword(input int c, input int s);
    return {16'hBEEF, 16'(c), 32'(s), 32'(s * 13), 32'hF00D_0000 + 32'(s)};
  endfunction

  req_t   creq0[$];
  req_t   creq1[$];
  cmd_t   cmdq[$];
  logic [DW-1:0] wexp[$];
  rbeat_t rexp[$];

  int wcur[2]  = '{0, 0};
  int wpush[2] = '{0, 0};
  int rseq = 0;
  int rd_left = 0, rd_gap_cnt = 0, rd_client = 0;
  int rd_gap_cfg = 0, rd_deliver_cfg = RDB;
  int wr_mode = 0;
  bit stray_req = 0, stray_active = 0;
  int cur_owner = 0;
  int cmd_count = 0, wr_burst_beats = 0, rd_beats_c1 = 0;

  // Scoreboard side: queue the command and the write beats the client will present.
  task automatic issue(input int c, input logic we, input logic [AW-1:0] a);
    req_t r;
    r.we = we;
    r.addr = a;
    if (c == 0) creq0.push_back(r);
    else        creq1.push_back(r);
    cmdq.push_back('{c: c, we: we, addr: a});
    if (we) begin
      for (int i = 0; i < WRB; i++) wexp.push_back(wword(c, wpush[c] + i));
      wpush[c] += WRB;
    end
  endtask

  // Negedge: compare DUT against the scoreboard; posedge+1: drive clients and the IP model.
  initial begin : ip_model
    logic [1:0] gnt_seen, adv;
    bit rd_start;
    cmd_t e;
    rbeat_t rb;
    forever begin
      @(negedge clk);
      gnt_seen = 2'b00;
      adv = 2'b00;
      rd_start = 0;
      if (rst_n) begin
        gnt_seen = c_gnt;
        if (ipb.cmd_en) begin
          cmd_count++;
          if (cmdq.size() == 0) begin
            check("cmd_unexpected", 1, 0);
          end else begin
            e = cmdq.pop_front();
            check("cmd", ipb.cmd, e.we ? 3'd0 : 3'd1);
            check("addr", ipb.addr, e.addr);
            check("burst_number", ipb.burst_number, e.we ? 6'(WRB - 1) : 6'(RDB - 1));
            check("gnt", c_gnt, (e.c == 1) ? 2'b10 : 2'b01);
            cur_owner = e.c;
            wr_burst_beats = 0;
            if (!e.we) rd_start = 1;
          end
        end else if (c_gnt != 2'b00) begin
          check("gnt_without_cmd", c_gnt, 0);
        end
        if (ipb.wr_data_en) begin
          wr_burst_beats++;
          check("wr_data_end", ipb.wr_data_end, 1);
          check("wdata_rd", c_wdata_rd, (cur_owner == 1) ? 2'b10 : 2'b01);
          if (wexp.size() == 0) check("wbeat_unexpected", 1, 0);
          else check("wr_data", ipb.wr_data, wexp.pop_front());
        end else if (c_wdata_rd != 2'b00) begin
          check("wdata_rd_idle", c_wdata_rd, 0);
        end
        adv = c_wdata_rd;
        if (c_rdata_vld != 2'b00) begin
          if (rexp.size() == 0) begin
            check("rbeat_unexpected", c_rdata_vld, 0);
          end else begin
            rb = rexp.pop_front();
            check("rdata_vld", c_rdata_vld, (rb.c == 1) ? 2'b10 : 2'b01);
            check("rdata", c_rdata, rb.d);
            if (rb.c == 1) rd_beats_c1++;
          end
        end
        if (stray_active) check("stray_rvld", c_rdata_vld, 0);
      end
      @(posedge clk);
      #1;
      for (int c = 0; c < 2; c++) begin
        if (adv[c]) wcur[c]++;
        c_wdata[c*DW +: DW] = wword(c, wcur[c]);
      end
      if (gnt_seen[0] && creq0.size() != 0) void'(creq0.pop_front());
      if (gnt_seen[1] && creq1.size() != 0) void'(creq1.pop_front());
      c_req[0] = (creq0.size() != 0);
      c_req[1] = (creq1.size() != 0);
      c_we[0]  = (creq0.size() != 0) ? creq0[0].we : 1'b0;
      c_we[1]  = (creq1.size() != 0) ? creq1[0].we : 1'b0;
      c_addr[0 +: AW]  = (creq0.size() != 0) ? creq0[0].addr : '0;
      c_addr[AW +: AW] = (creq1.size() != 0) ? creq1[0].addr : '0;
      ipb.wr_data_rdy = (wr_mode == 0) ? 1'b1 : ~ipb.wr_data_rdy;
      stray_active = 0;
      ipb.rd_data_valid = 1'b0;
      ipb.rd_data = '0;
      if (rd_start) begin
        rd_left = rd_deliver_cfg;
        rd_gap_cnt = rd_gap_cfg;
        rd_client = cur_owner;
      end
      if (rd_left > 0) begin
        if (rd_gap_cnt == 0) begin
          ipb.rd_data_valid = 1'b1;
          ipb.rd_data = rword(rd_client, rseq);
          rexp.push_back('{c: rd_client, d: rword(rd_client, rseq)});
          rseq++;
          rd_left--;
          rd_gap_cnt = rd_gap_cfg;
        end else begin
          rd_gap_cnt--;
        end
      end else if (stray_req) begin
        ipb.rd_data_valid = 1'b1;
        ipb.rd_data = rword(1, 999);
        stray_req = 0;
        stray_active = 1;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit done;
    done = 0;
    for (int n = 0; n < budget && !done; n++) begin
      @(posedge clk);
      #2;
      done = (cmdq.size() == 0) && (wexp.size() == 0) && (rexp.size() == 0) && (rd_left == 0)
             && (creq0.size() == 0) && (creq1.size() == 0);
    end
    if (!done) check({tag, "_budget"}, 0, 1);
    cycles(3);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_cmd_en"}, ipb.cmd_en, 0);
    check({tag, "_cmd"}, ipb.cmd, 3'd1);
    check({tag, "_burst"}, ipb.burst_number, 6'(RDB - 1));
    check({tag, "_addr"}, ipb.addr, 0);
    check({tag, "_gnt"}, c_gnt, 0);
    check({tag, "_wr_en"}, {ipb.wr_data_en, ipb.wr_data_end, c_wdata_rd}, 0);
    check({tag, "_wr_data"}, ipb.wr_data, 0);
    check({tag, "_rvld"}, c_rdata_vld, 0);
    check({tag, "_rdata"}, c_rdata, 0);
    check({tag, "_err"}, rd_timeout_err, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    creq0.delete();
    creq1.delete();
    cmdq.delete();
    wexp.delete();
    rexp.delete();
    rd_left = 0;
    wcur[0] = 0; wcur[1] = 0;
    wpush[0] = 0; wpush[1] = 0;
    c_wdata = {wword(1, 0), wword(0, 0)};
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
  endtask

  initial begin : stimulus
    int n, base;
    rst_n = 1'b0;
    ipb.init_done = 1'b0;
    ipb.cmd_rdy = 1'b1;
    ipb.wr_data_rdy = 1'b1;
    ipb.rd_data_valid = 1'b0;
    ipb.rd_data = '0;
    c_req = 2'b00;
    c_we = 2'b00;
    c_addr = '0;
    c_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    cycles(1);
    rst_n = 1'b1;
    cycles(2);
    ipb.init_done = 1'b1;

    // Single write from client 0.
    base = cmd_count;
    issue(0, 1'b1, 27'h0001000);
    wait_idle(200, "t1");
    check("t1_cmds", cmd_count - base, 1);
    check("t1_beats", wr_burst_beats, WRB);

    // Simultaneous requests from reset: client 0 first, then alternation.
    do_reset();
    base = cmd_count;
    issue(0, 1'b1, 27'h0002000);
    issue(1, 1'b0, 27'h0100040);
    issue(0, 1'b1, 27'h0002100);
    issue(1, 1'b0, 27'h0100080);
    wait_idle(600, "t2");
    check("t2_cmds", cmd_count - base, 4);

    // Write with wr_data_rdy toggling every cycle.
    wr_mode = 1;
    issue(0, 1'b1, 27'h0003000);
    wait_idle(300, "t3");
    check("t3_beats", wr_burst_beats, WRB);
    wr_mode = 0;

    // Read with 3-cycle gaps between beats.
    rd_gap_cfg = 3;
    base = rd_beats_c1;
    issue(1, 1'b0, 27'h0200000);
    wait_idle(300, "t4");
    check("t4_rbeats", rd_beats_c1 - base, RDB);
    rd_gap_cfg = 0;

    // Short read: only 5 beats, the burst must time out.
    rd_deliver_cfg = 5;
    base = rd_beats_c1;
    issue(1, 1'b0, 27'h0300000);
    n = 0;
    while (!rd_timeout_err && n < TMO + 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("t5_tmo_window", (n >= TMO && n <= TMO + 10), 1);
    check("t5_err", rd_timeout_err, 1);
    check("t5_rbeats", rd_beats_c1 - base, 5);
    rd_deliver_cfg = RDB;
    issue(0, 1'b1, 27'h0004000);
    wait_idle(300, "t5_next");
    check("t5_next_beats", wr_burst_beats, WRB);
    check("t5_err_sticky", rd_timeout_err, 1);

    // Stray read beat with no read outstanding.
    stray_req = 1;
    cycles(5);

    // Request withdrawn while calibration is low never issues a command.
    ipb.init_done = 1'b0;
    cycles(3);
    base = cmd_count;
    begin
      req_t r;
      r.we = 1'b0;
      r.addr = 27'h0500000;
      creq1.push_back(r);
    end
    cycles(5);
    creq1.delete();
    cycles(2);
    ipb.init_done = 1'b1;
    cycles(20);
    check("t7_no_cmd", cmd_count - base, 0);

    // Reset in the middle of a write burst, then a fresh write from beat 0.
    issue(0, 1'b1, 27'h0006000);
    n = 0;
    while (wr_burst_beats != 7 && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("t6_reach_beat7", wr_burst_beats, 7);
    rst_n = 1'b0;
    creq0.delete();
    cmdq.delete();
    wexp.delete();
    wcur[0] = 0;
    wpush[0] = 0;
    c_wdata[0 +: DW] = wword(0, 0);
    @(negedge clk);
    check_quiet("t6_rst");
    cycles(1);
    rst_n = 1'b1;
    cycles(2);
    issue(0, 1'b1, 27'h0007000);
    wait_idle(200, "t6");
    check("t6_beats", wr_burst_beats, WRB);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
endmodule
